// File: rtl/receptor_pkg.sv
// Shared definitions for the receive stage: handshake state encoding and default sizes.
package receptor_pkg;

  // Handshake states: waiting for a request, or holding ack until send drops
  typedef enum logic {
    ESPERA = 1'b0,
    ACK    = 1'b1
  } estado_t;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 4;

endpackage

// File: rtl/fifo_sinc.sv
// Single-clock FIFO with first-word-fall-through read port and occupancy count.
module fifo_sinc
  import receptor_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_dados,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_dados,
  output logic              vazio,
  output logic              cheio,
  output logic [PTR_W:0]    count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    count_d;
  logic              wr_ok;
  logic              rd_ok;

  // Flags come from the registered count; a full FIFO never takes a write, even on a pop
  always_comb begin
    vazio    = (count_q == '0);
    cheio    = (count_q == (PTR_W + 1)'(DEPTH));
    wr_ok    = wr_en && !cheio;
    rd_ok    = rd_en && !vazio;
    rd_dados = mem_q[rd_ptr_q];
    count    = count_q;
  end

  // Occupancy next state: simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage array, cleared on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_dados;
    end
  end

endmodule

// File: rtl/receptor_fifo.sv
// Receive stage: four-phase send/ack handshake feeding a FWFT FIFO, ack withheld while full.
module receptor_fifo
  import receptor_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              rx_clock,
  input  logic              rx_reset,
  input  logic              rx_send,
  input  logic [DATA_W-1:0] rx_dados,
  output logic              rx_ack,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_dados,
  output logic              rd_vazio,
  output logic              rd_cheio,
  output logic [PTR_W:0]    rd_count,
  output logic [7:0]        rx_total
);

  estado_t    state_q;
  estado_t    state_d;
  logic       wr_en;
  logic [7:0] rx_total_q;

  // State register; reset drops ack asynchronously because ack decodes the state
  always_ff @(posedge rx_clock or negedge rx_reset) begin
    if (!rx_reset) state_q <= ESPERA;
    else           state_q <= state_d;
  end

  // Next state: accept only when not full, release only once send returns low
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ESPERA:  if (rx_send && !rd_cheio) state_d = ACK;
      ACK:     if (!rx_send) state_d = ESPERA;
      default: state_d = ESPERA;
    endcase
  end

  // Outputs: exactly one write per handshake, on the ESPERA->ACK transition
  always_comb begin
    rx_ack   = (state_q == ACK);
    wr_en    = (state_q == ESPERA) && rx_send && !rd_cheio;
    rx_total = rx_total_q;
  end

  // Accepted-word counter, wraps at 8 bits
  always_ff @(posedge rx_clock or negedge rx_reset) begin
    if (!rx_reset)  rx_total_q <= '0;
    else if (wr_en) rx_total_q <= rx_total_q + 8'd1;
  end

  fifo_sinc #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clock    (rx_clock),
    .reset    (rx_reset),
    .wr_en    (wr_en),
    .wr_dados (rx_dados),
    .rd_en    (rd_en),
    .rd_dados (rd_dados),
    .vazio    (rd_vazio),
    .cheio    (rd_cheio),
    .count    (rd_count)
  );

endmodule
